// File: rtl/bus_initiator.sv
// Single-outstanding peripheral bus initiator: accepts one core load/store, strobes bus_we once,
// waits WAIT_CYCLES bus cycles, samples read data, then pulses resp_valid for one cycle.
module bus_initiator #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic          resp_we,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    input  logic [DW-1:0] bus_rdata,
    output logic [1:0]    dbg_state
);

    if (WAIT_CYCLES > 15) begin : g_wait_check
        $error("bus_initiator: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is
    // high only in IDLE, so requests presented while busy simply wait and are never queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d = 4'd0;
                if (WAIT_CYCLES == 0) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobe decoded from the registered state so it can only ever last the single SETUP cycle.
    assign req_ready  = (state_q == S_IDLE);
    assign bus_we     = (state_q == S_SETUP) && we_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_we    = (state_q == S_RESP) && we_q;
    assign resp_rdata = rdata_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: three instances (WAIT_CYCLES 0, 1, 3) on bench-side timer/RAM responders,
// checked every cycle against a transaction-level model of the bus protocol.
module tb_bus_initiator;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [15:0] req_addr [3];
    logic [15:0] req_wdata [3];
    logic [15:0] bus_rdata [3];
    wire  [2:0]  req_ready;
    wire  [2:0]  resp_valid;
    wire  [2:0]  resp_we;
    wire  [2:0]  bus_we;
    wire  [15:0] resp_rdata [3];
    wire  [15:0] bus_addr [3];
    wire  [15:0] bus_wdata [3];
    wire  [1:0]  dbg_state [3];

    bus_initiator #(.WAIT_CYCLES(0), .AW(16), .DW(16)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_we(resp_we[0]), .resp_rdata(resp_rdata[0]),
        .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]), .bus_we(bus_we[0]),
        .bus_rdata(bus_rdata[0]), .dbg_state(dbg_state[0])
    );
    bus_initiator #(.WAIT_CYCLES(1), .AW(16), .DW(16)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_we(resp_we[1]), .resp_rdata(resp_rdata[1]),
        .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]), .bus_we(bus_we[1]),
        .bus_rdata(bus_rdata[1]), .dbg_state(dbg_state[1])
    );
    bus_initiator #(.WAIT_CYCLES(3), .AW(16), .DW(16)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_we(resp_we[2]), .resp_rdata(resp_rdata[2]),
        .bus_addr(bus_addr[2]), .bus_wdata(bus_wdata[2]), .bus_we(bus_we[2]),
        .bus_rdata(bus_rdata[2]), .dbg_state(dbg_state[2])
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- responders: timer at 0x0000, RAM at 0x01xx, zero elsewhere ----------------
    logic [15:0] timer_r [3] = '{default: 16'h0};
    logic [15:0] ram_r [3][16] = '{default: '{default: 16'h0}};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (bus_we[k] && bus_addr[k] == 16'h0000) timer_r[k] <= bus_wdata[k];
            else timer_r[k] <= timer_r[k] + 16'd1;
            if (bus_we[k] && bus_addr[k][8]) ram_r[k][bus_addr[k][3:0]] <= bus_wdata[k];
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            bus_rdata[k] = 16'h0000;
            if (bus_addr[k] == 16'h0000) bus_rdata[k] = timer_r[k];
            else if (bus_addr[k][8]) bus_rdata[k] = ram_r[k][bus_addr[k][3:0]];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int w_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // ---------------- reference model + scoreboard ----------------
    // Each transaction accepted in cycle t: SETUP in t+1 (strobe if store), read sampled at the end
    // of cycle t+1+W, response in cycle t+2+W, ready again from t+3+W.
    logic [17:0] exp_q [$];
    int          acc_c [3];
    logic        has_txn [3];
    logic        t_we [3];
    logic [15:0] exp_addr [3];
    logic [15:0] exp_wdata [3];
    logic [15:0] exp_rdata [3];
    logic [15:0] mdl_mem [3][16];
    logic [15:0] tb_val [3];
    int          tb_cyc [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            has_txn[k] = 1'b0; acc_c[k] = 0; t_we[k] = 1'b0;
            exp_addr[k] = 16'h0; exp_wdata[k] = 16'h0; exp_rdata[k] = 16'h0;
            tb_val[k] = 16'h0; tb_cyc[k] = 0;
            for (int i = 0; i < 16; i++) mdl_mem[k][i] = 16'h0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int   w, c, sc;
                logic busy, resp_now, found;
                logic [15:0] rd;
                w = w_of(k);
                c = cyc;
                busy = has_txn[k] && (c > acc_c[k]) && (c <= acc_c[k] + 2 + w);
                resp_now = busy && (c == acc_c[k] + 2 + w);
                if (resp_now) begin
                    found = 1'b0;
                    for (int i = 0; i < exp_q.size() && !found; i++) begin
                        if (exp_q[i][17:16] == 2'(k)) begin
                            exp_rdata[k] = exp_q[i][15:0];
                            exp_q.delete(i);
                            found = 1'b1;
                        end
                    end
                    check($sformatf("u%0d_scoreboard_entry", k), 32'(found), 32'd1);
                end
                check($sformatf("u%0d_req_ready", k), 32'(req_ready[k]), 32'(!busy));
                check($sformatf("u%0d_bus_we", k), 32'(bus_we[k]),
                      32'(busy && (c == acc_c[k] + 1) && t_we[k]));
                check($sformatf("u%0d_resp_valid", k), 32'(resp_valid[k]), 32'(resp_now));
                check($sformatf("u%0d_resp_we", k), 32'(resp_we[k]), 32'(resp_now && t_we[k]));
                check($sformatf("u%0d_bus_addr", k), 32'(bus_addr[k]), 32'(exp_addr[k]));
                check($sformatf("u%0d_bus_wdata", k), 32'(bus_wdata[k]), 32'(exp_wdata[k]));
                check($sformatf("u%0d_resp_rdata", k), 32'(resp_rdata[k]), 32'(exp_rdata[k]));
                if (rst == 1'b0) begin
                    has_txn[k] = 1'b0;
                    exp_addr[k] = 16'h0; exp_wdata[k] = 16'h0; exp_rdata[k] = 16'h0;
                    for (int i = exp_q.size() - 1; i >= 0; i--)
                        if (exp_q[i][17:16] == 2'(k)) exp_q.delete(i);
                end else if (req_valid[k] && !busy) begin
                    has_txn[k] = 1'b1;
                    acc_c[k] = c;
                    t_we[k] = req_we[k];
                    exp_addr[k] = req_addr[k];
                    exp_wdata[k] = req_wdata[k];
                    rd = exp_rdata[k];
                    if (req_we[k]) begin
                        if (req_addr[k] == 16'h0000) begin
                            tb_val[k] = req_wdata[k];
                            tb_cyc[k] = c + 2;
                        end
                        if (req_addr[k][8]) mdl_mem[k][req_addr[k][3:0]] = req_wdata[k];
                    end else begin
                        sc = c + 1 + w;
                        if (req_addr[k] == 16'h0000) rd = tb_val[k] + 16'(sc - tb_cyc[k]);
                        else if (req_addr[k][8]) rd = mdl_mem[k][req_addr[k][3:0]];
                        else rd = 16'h0000;
                    end
                    exp_q.push_back({2'(k), rd});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input int k, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        logic got;
        got = 1'b0;
        req_valid[k] = 1'b1;
        req_we[k] = we;
        req_addr[k] = addr;
        req_wdata[k] = wdata;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[k]) got = 1'b1;
            @(posedge clk);
            #1;
        end
        check($sformatf("u%0d_accept_within_budget", k), 32'(got), 32'd1);
        req_valid[k] = 1'b0;
        req_we[k] = 1'($urandom);
        req_addr[k] = 16'($urandom);
        req_wdata[k] = 16'($urandom);
    endtask

    task automatic wait_idle(input int k);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[k]) got = 1'b1;
            @(posedge clk);
            #1;
        end
        check($sformatf("u%0d_idle_within_budget", k), 32'(got), 32'd1);
    endtask

    function automatic logic [15:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return 16'h0000;
        if (sel == 1) return 16'h0004;
        return {12'h010, 4'($urandom_range(0, 7))};
    endfunction

    task automatic random_phase(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            do_req(k, 1'($urandom), rand_addr(), 16'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(k);
    endtask

    // Valid held high throughout; fields scrambled while busy, real request shown on each idle cycle.
    task automatic held_phase(input int k, input int n_txn);
        int   n, gap, last;
        n = 0; gap = 0; last = 0;
        req_valid[k] = 1'b1;
        for (int i = 0; i < 120 && n < n_txn; i++) begin
            if (gap > 0) begin
                req_we[k] = 1'($urandom);
                req_addr[k] = 16'($urandom);
                req_wdata[k] = 16'($urandom);
                gap--;
            end else begin
                req_we[k] = (n % 2 == 0);
                req_addr[k] = 16'h0108 | 16'(n / 2);
                req_wdata[k] = 16'($urandom);
            end
            @(negedge clk);
            if (req_ready[k]) begin
                if (n > 0) check("u2_accept_spacing", 32'(cyc - last), 32'(3 + w_of(k)));
                last = cyc;
                n++;
                gap = 2 + w_of(k);
            end
            @(posedge clk);
            #1;
        end
        req_valid[k] = 1'b0;
        check("u2_held_accept_count", 32'(n), 32'(n_txn));
        wait_idle(k);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        req_valid = 3'b000;
        req_we = 3'b000;
        for (int k = 0; k < 3; k++) begin
            req_addr[k] = 16'h0;
            req_wdata[k] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // W=1: store to timer, then back-to-back load of the timer.
        do_req(1, 1'b1, 16'h0000, 16'h1234);
        wait_idle(1);
        check("u1_store_keeps_rdata", 32'(resp_rdata[1]), 32'h0000);
        do_req(1, 1'b1, 16'h0000, 16'h1234);
        do_req(1, 1'b0, 16'h0000, 16'h0000);
        wait_idle(1);
        check("u1_timer_load_value", 32'(resp_rdata[1]), 32'h1238);

        // W=0: RAM round trip, then load from the zero register.
        do_req(0, 1'b1, 16'h0102, 16'h5A5A);
        do_req(0, 1'b0, 16'h0102, 16'h0000);
        wait_idle(0);
        check("u0_ram_readback", 32'(resp_rdata[0]), 32'h5A5A);
        do_req(0, 1'b0, 16'h0004, 16'hFFFF);
        wait_idle(0);
        check("u0_zero_reg_load", 32'(resp_rdata[0]), 32'h0000);

        // W=3: held valid, alternating store/load.
        held_phase(2, 8);

        // Request fields change right after acceptance; latched values must stay.
        do_req(2, 1'b1, 16'h0105, 16'hBEEF);
        @(negedge clk);
        check("u2_bus_addr_latched", 32'(bus_addr[2]), 32'h0105);
        check("u2_bus_wdata_latched", 32'(bus_wdata[2]), 32'hBEEF);
        @(posedge clk);
        #1;
        wait_idle(2);

        for (int k = 0; k < 3; k++) random_phase(k, 25);

        // Reset for two cycles in the middle of a W=3 load's WAIT phase.
        do_req(2, 1'b0, 16'h0105, 16'h0000);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("u2_ready_after_reset", 32'(req_ready[2]), 32'd1);
        check("u2_bus_we_after_reset", 32'(bus_we[2]), 32'd0);
        check("u2_dbg_state_after_reset", 32'(dbg_state[2]), 32'd0);
        @(posedge clk);
        #1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 3; k++) random_phase(k, 15);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
